// File: rtl/xadc_seq_bfm.sv
// Behavioural stand-in for an XADC running a continuous aux-channel sequence.
// Conversions are synthetic: each channel's code ramps by RAMP_STEP per
// conversion. A DRP port gives fixed-latency access to the result registers.
module xadc_seq_bfm #(
  parameter int unsigned                 NUM_CHANNELS = 2,
  parameter logic [NUM_CHANNELS*5-1:0]   CHANNEL_MAP  = {5'd12, 5'd4},
  parameter int unsigned                 CONV_CYCLES  = 26,
  parameter int unsigned                 DRP_LATENCY  = 2,
  parameter int unsigned                 RAMP_STEP    = 1
) (
  input  logic                    dclk_in,
  input  logic                    reset_n_in,
  input  logic [15:0]             di_in,
  input  logic [6:0]              daddr_in,
  input  logic                    den_in,
  input  logic                    dwe_in,
  output logic                    drdy_out,
  output logic [15:0]             do_out,
  input  logic                    vp_in,
  input  logic                    vn_in,
  input  logic [NUM_CHANNELS-1:0] vauxp_in,
  input  logic [NUM_CHANNELS-1:0] vauxn_in,
  output logic [4:0]              channel_out,
  output logic                    eoc_out,
  output logic                    eos_out,
  output logic                    alarm_out,
  output logic                    busy_out
);

  localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned LatW = $clog2(DRP_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q;
  logic [11:0]       code_q [NUM_CHANNELS];

  logic              pend_q;
  logic [LatW-1:0]   lat_q;
  logic [15:0]       rdata_q;

  logic                    done_fire;
  logic                    last_idx;
  logic                    accept;
  logic [NUM_CHANNELS-1:0] addr_hit;
  logic [NUM_CHANNELS-1:0] wr_hit;
  logic [15:0]             rd_val;

  function automatic logic [4:0] map_entry(input int unsigned i);
    return CHANNEL_MAP[i*5 +: 5];
  endfunction

  // The edge that enters DONE: the conversion result and flags land together.
  assign done_fire = (state_q == StConvert) && (cnt_q == CntW'(CONV_CYCLES - 1));
  assign last_idx  = (idx_q == IdxW'(NUM_CHANNELS - 1));
  assign accept    = den_in && !pend_q;
  assign wr_hit    = addr_hit & {NUM_CHANNELS{accept && dwe_in}};
  assign alarm_out = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{vp_in, vn_in, vauxp_in, vauxn_in, di_in[3:0]};

  // Sequencer: IDLE -> CONVERT (CONV_CYCLES busy cycles) -> DONE (one cycle) -> CONVERT.
  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_out    <= 1'b0;
      eoc_out     <= 1'b0;
      eos_out     <= 1'b0;
      channel_out <= 5'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q  <= StConvert;
          cnt_q    <= '0;
          busy_out <= 1'b1;
        end
        StConvert: begin
          if (done_fire) begin
            state_q     <= StDone;
            busy_out    <= 1'b0;
            eoc_out     <= 1'b1;
            eos_out     <= last_idx;
            channel_out <= 5'd16 + map_entry(32'(idx_q));
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q  <= StConvert;
          cnt_q    <= '0;
          busy_out <= 1'b1;
          eoc_out  <= 1'b0;
          eos_out  <= 1'b0;
          idx_q    <= last_idx ? '0 : idx_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // DRP address decode and read-back value from the current (pre-update) codes.
  always_comb begin
    addr_hit = '0;
    rd_val   = 16'h0000;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (daddr_in == 7'h10 + {2'b00, map_entry(i)}) begin
        addr_hit[i] = 1'b1;
        rd_val      = {code_q[i], 4'b0000};
      end
    end
  end

  // Channel codes: a DRP write on the same edge as a DONE update takes priority.
  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) code_q[i] <= 12'd0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_hit[i]) begin
          code_q[i] <= di_in[15:4];
        end else if (done_fire && (idx_q == IdxW'(i))) begin
          code_q[i] <= code_q[i] + 12'(RAMP_STEP);
        end
      end
    end
  end

  // DRP transaction: capture at accept, answer DRP_LATENCY edges later.
  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pend_q   <= 1'b0;
      lat_q    <= '0;
      rdata_q  <= 16'h0000;
      drdy_out <= 1'b0;
      do_out   <= 16'h0000;
    end else begin
      drdy_out <= 1'b0;
      do_out   <= 16'h0000;
      if (accept) begin
        pend_q  <= 1'b1;
        lat_q   <= LatW'(1);
        rdata_q <= dwe_in ? 16'h0000 : rd_val;
      end else if (pend_q) begin
        if (lat_q == LatW'(DRP_LATENCY)) begin
          pend_q   <= 1'b0;
          drdy_out <= 1'b1;
          do_out   <= rdata_q;
        end else begin
          lat_q <= lat_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/xadc_seq_bfm.md
XADC_SEQ_BFM -- requirements
Module: xadc_seq_bfm

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of aux channels in the continuous sequence (legal 1..16).
REQ-002 SHALL have parameter CHANNEL_MAP, default {5'd12, 5'd4}, packed NUM_CHANNELS x 5-bit aux channel numbers; entry 0 (LSBs) is converted first.
REQ-003 SHALL have parameter CONV_CYCLES, default 26, busy cycles per conversion (legal >= 1).
REQ-004 SHALL have parameter DRP_LATENCY, default 2, cycles from accepted den_in to drdy_out (legal >= 1).
REQ-005 SHALL have parameter RAMP_STEP, default 1, 12-bit code increment per conversion of a channel.
REQ-006 dclk_in  in  1  sole clock; all logic on rising edge.
REQ-007 reset_n_in  in  1  asynchronous, active-low reset.
REQ-008 di_in  in  16  DRP write data.
REQ-009 daddr_in  in  7  DRP address.
REQ-010 den_in  in  1  DRP enable, one-cycle strobe.
REQ-011 dwe_in  in  1  DRP write enable, valid with den_in.
REQ-012 drdy_out  out  1  one-cycle DRP completion pulse.
REQ-013 do_out  out  16  DRP read data, valid only with drdy_out.
REQ-014 vp_in, vn_in  in  1 each  unused.
REQ-015 vauxp_in, vauxn_in  in  NUM_CHANNELS each  unused; conversions are synthetic.
REQ-016 channel_out  out  5  channel code (16 + aux number) of last completed conversion.
REQ-017 eoc_out  out  1  end-of-conversion pulse.
REQ-018 eos_out  out  1  end-of-sequence pulse.
REQ-019 alarm_out  out  1  alarm OR; constant 0.
REQ-020 busy_out  out  1  conversion in progress.

Function
REQ-021 Per channel i SHALL hold a 12-bit code; result register reads as {code, 4'b0}.
REQ-022 Sequencer SHALL have states IDLE, CONVERT, DONE; IDLE -> CONVERT on the first cycle after reset release with channel index 0.
REQ-023 In CONVERT busy_out SHALL be 1 for exactly CONV_CYCLES cycles, then go to DONE.
REQ-024 In DONE (one cycle) busy_out=0, eoc_out=1, channel_out=16+CHANNEL_MAP[i], code[i] += RAMP_STEP mod 4096 (4095+1 wraps to 0), registered on the DONE entry edge so all are visible together.
REQ-025 eos_out SHALL be 1 only in the DONE cycle of channel NUM_CHANNELS-1; index then wraps to 0.
REQ-026 DONE -> CONVERT for the next index; sequence period SHALL be NUM_CHANNELS x (CONV_CYCLES+1) cycles.
REQ-027 DRP is accepted when den_in=1 and no transaction is pending; den_in while pending SHALL be ignored.
REQ-028 Read of address 7'h10+CHANNEL_MAP[i] SHALL return that channel's result value captured at the accept edge.
REQ-029 Read of any other address SHALL return 16'h0000.
REQ-030 Write (dwe_in=1) to a mapped address SHALL load code[i] <= di_in[15:4]; other addresses ignored; do_out=0 for writes.
REQ-031 drdy_out SHALL pulse exactly DRP_LATENCY cycles after the accept edge, for one cycle; do_out SHALL be 0 whenever drdy_out=0.
REQ-032 A write and a DONE update to the same channel on one edge: the write SHALL win.
REQ-033 A read accepted on a DONE edge for the same channel SHALL return the pre-update value.
REQ-034 DRP and sequencer SHALL run independently; DRP traffic never stalls conversions.

Reset
REQ-035 reset_n_in=0 SHALL immediately force drdy_out, do_out, channel_out, eoc_out, eos_out, alarm_out, busy_out to 0, all codes to 0, state IDLE, index 0, and drop any pending DRP transaction (no drdy_out).
REQ-036 Reset asserted mid-conversion or mid-DRP SHALL behave identically to REQ-035; restart per REQ-022.

Verification
REQ-037 Defaults, release reset -> busy_out high cycles 1..26, eoc_out at cycle 27 with channel_out=5'h14, eoc+eos at cycle 54 with channel_out=5'h1C.
REQ-038 After first eos, read 7'h14 -> drdy_out exactly 2 cycles after accept, do_out=16'h0010; read 7'h1C -> 16'h0010.
REQ-039 Write 7'h14 di_in=16'hFFF0, then one conversion of ch4 -> read returns 16'h0000 (wrap).
REQ-040 Read 7'h15 -> do_out=16'h0000 with drdy_out; second den_in during pending read -> exactly one drdy_out.
REQ-041 NUM_CHANNELS=3, CHANNEL_MAP={5'd1,5'd12,5'd4}, CONV_CYCLES=4 -> eoc every 5 cycles, channel_out 14,1C,11 repeating, eos every 15 cycles.
REQ-042 Assert reset_n_in mid-CONVERT with read pending -> all outputs 0 asynchronously, no drdy_out, restart per REQ-037.
